// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch PC generator.
// Holds the FSM state encoding, the default parameter values and the alignment-mask helper.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } pc_state_e;

  localparam int unsigned DEF_ADDR_W    = 32;
  localparam int unsigned DEF_STEP      = 4;
  localparam int unsigned DEF_NUM_REDIR = 2;
  localparam int unsigned DEF_RAS_DEPTH = 4;

  // Mask of the low address bits that must be zero for a STEP-aligned PC.
  function automatic logic [63:0] align_mask(input int unsigned step);
    int unsigned sh;
    sh = $clog2(step);
    return (64'd1 << sh) - 64'd1;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack with a top pointer and an occupancy count.
// A push into a full stack overwrites the oldest entry; push plus pop replaces the top in place.
module pc_ras
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [ADDR_W-1:0] mem_d [RAS_DEPTH];
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, empty_d;

  always_comb begin
    mem_d   = mem_q;
    top_d   = top_q;
    count_d = count_q;
    if (push_i && pop_i && count_q != '0) begin
      mem_d[top_q] = push_addr_i;
    end else if (push_i) begin
      // Slot above the top is free, or holds the oldest entry once the stack is full.
      top_d        = top_q + PTR_W'(1);
      mem_d[top_d] = push_addr_i;
      if (count_q != CNT_FULL) count_d = count_q + CNT_W'(1);
    end else if (pop_i && count_q != '0) begin
      top_d   = top_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q   <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign top_o   = mem_q[top_q];
  assign empty_o = empty_q;
  assign full_o  = (count_q == CNT_FULL);

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: selects the next PC from reset, redirects, RAS pop, hold or increment.
// Handshake: a fetch is accepted on any edge where fetch_valid_o && fetch_ready_i; while valid is high and ready low, pc_o is stable unless a reset, redirect or pop overrides it.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int unsigned       STEP       = DEF_STEP,
  parameter int unsigned       NUM_REDIR  = DEF_NUM_REDIR,
  parameter int unsigned       RAS_DEPTH  = DEF_RAS_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        jtag_reset_i,
  input  logic [NUM_REDIR-1:0]        redir_valid_i,
  input  logic [NUM_REDIR*ADDR_W-1:0] redir_addr_i,
  input  logic                        hold_i,
  input  logic                        ras_push_i,
  input  logic [ADDR_W-1:0]           ras_push_addr_i,
  input  logic                        ras_pop_i,
  input  logic                        fetch_ready_i,
  output logic                        fetch_valid_o,
  output logic [ADDR_W-1:0]           pc_o,
  output logic                        misalign_o,
  output logic                        ras_empty_o,
  output pc_state_e                   state_o
);

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(align_mask(STEP));

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              misalign_q, misalign_d;

  logic              reset_any;
  logic              any_redir;
  logic [ADDR_W-1:0] redir_tgt;
  logic              pop_take;
  logic              push_take;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_full;

  assign reset_any = rst | jtag_reset_i;
  assign push_take = ras_push_i & ~reset_any;

  // Walk from the highest index down so the lowest asserted channel wins.
  always_comb begin
    any_redir = 1'b0;
    redir_tgt = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--) begin
      if (redir_valid_i[k]) begin
        any_redir = 1'b1;
        redir_tgt = redir_addr_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    pop_take   = 1'b0;
    if (reset_any) begin
      state_d = ST_RESET;
      pc_d    = RESET_ADDR;
    end else begin
      state_d = hold_i ? ST_HOLD : ST_RUN;
      if (any_redir) begin
        pc_d       = redir_tgt & ~LOW_MASK;
        misalign_d = |(redir_tgt & LOW_MASK);
      end else if (ras_pop_i && !ras_empty) begin
        pc_d     = ras_top;
        pop_take = 1'b1;
      end else if (hold_i || (valid_q && !fetch_ready_i)) begin
        pc_d = pc_q;
      end else if (valid_q && fetch_ready_i) begin
        pc_d = pc_q + ADDR_W'(STEP);
      end
    end
    valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset_any) begin
      state_q    <= ST_RESET;
      pc_q       <= RESET_ADDR;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (reset_any),
    .push_i      (push_take),
    .push_addr_i (ras_push_addr_i),
    .pop_i       (pop_take),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .full_o      (ras_full)
  );

  // The registered empty flag and the live full flag come from the same count.
  always_ff @(posedge clk) begin
    if (!reset_any) begin
      assert (!(ras_full && ras_empty));
    end
  end

  assign fetch_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign misalign_o    = misalign_q;
  assign ras_empty_o   = ras_empty;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: each vector queues its hand-computed post-edge outputs,
// and an independent monitor pops and compares them one cycle at a time.
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned EW = AW + 3;

  logic            clk;
  logic            rst;
  logic            jtag_reset_i;
  logic [1:0]      redir_valid_i;
  logic [AW-1:0]   addr0, addr1;
  logic [2*AW-1:0] redir_addr_i;
  logic            hold_i;
  logic            ras_push_i;
  logic [AW-1:0]   ras_push_addr_i;
  logic            ras_pop_i;
  logic            fetch_ready_i;
  logic            fetch_valid_o;
  logic [AW-1:0]   pc_o;
  logic            misalign_o;
  logic            ras_empty_o;
  pc_state_e       dbg_state;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_assert;
  int            n_fail;

  assign redir_addr_i = {addr1, addr0};

  pc_gen dut (
    .clk             (clk),
    .rst             (rst),
    .jtag_reset_i    (jtag_reset_i),
    .redir_valid_i   (redir_valid_i),
    .redir_addr_i    (redir_addr_i),
    .hold_i          (hold_i),
    .ras_push_i      (ras_push_i),
    .ras_push_addr_i (ras_push_addr_i),
    .ras_pop_i       (ras_pop_i),
    .fetch_ready_i   (fetch_ready_i),
    .fetch_valid_o   (fetch_valid_o),
    .pc_o            (pc_o),
    .misalign_o      (misalign_o),
    .ras_empty_o     (ras_empty_o),
    .state_o         (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: queue the expectation, let one edge pass, then drop single-cycle pulses.
  task automatic cyc(input string nm, input logic [AW-1:0] pc, input logic v,
                     input logic m, input logic e);
    exp_q.push_back({pc, v, m, e});
    name_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
    redir_valid_i = 2'b00;
    ras_push_i    = 1'b0;
    ras_pop_i     = 1'b0;
    jtag_reset_i  = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] a);
    ras_push_i      = 1'b1;
    ras_push_addr_i = a;
  endtask

  task automatic redir(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    redir_valid_i = v;
    addr0         = a0;
    addr1         = a1;
  endtask

  // Scoreboard monitor
  always begin
    logic [EW-1:0] e;
    string         nm;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_assert++;
      if ({pc_o, fetch_valid_o, misalign_o, ras_empty_o} !== e) begin
        n_fail++;
        $display("FAIL %s: got pc=%h valid=%b misalign=%b empty=%b, expected pc=%h valid=%b misalign=%b empty=%b",
                 nm, pc_o, fetch_valid_o, misalign_o, ras_empty_o,
                 e[EW-1:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    n_assert        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    jtag_reset_i    = 1'b0;
    redir_valid_i   = 2'b00;
    addr0           = '0;
    addr1           = '0;
    hold_i          = 1'b0;
    ras_push_i      = 1'b0;
    ras_push_addr_i = '0;
    ras_pop_i       = 1'b0;
    fetch_ready_i   = 1'b0;

    // Reset and sequential stream
    for (int i = 0; i < 3; i++) cyc("reset", 32'h0, 0, 0, 1);
    rst = 1'b0; fetch_ready_i = 1'b1;
    cyc("first_valid", 32'h0, 1, 0, 1);
    cyc("stream_4", 32'h4, 1, 0, 1);
    cyc("stream_8", 32'h8, 1, 0, 1);
    cyc("stream_c", 32'hC, 1, 0, 1);
    cyc("stream_10", 32'h10, 1, 0, 1);

    // Backpressure then hold
    fetch_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) cyc("backpressure", 32'h10, 1, 0, 1);
    hold_i = 1'b1;
    cyc("hold_1", 32'h10, 0, 0, 1);
    cyc("hold_2", 32'h10, 0, 0, 1);
    hold_i = 1'b0; fetch_ready_i = 1'b1;
    cyc("hold_release", 32'h10, 1, 0, 1);
    cyc("resume_14", 32'h14, 1, 0, 1);

    // Redirect priority and misalignment
    redir(2'b11, 32'h100, 32'h200);
    cyc("redir_prio", 32'h100, 1, 0, 1);
    redir(2'b10, 32'h0, 32'h203);
    cyc("redir_misalign", 32'h200, 1, 1, 1);
    cyc("misalign_drop", 32'h204, 1, 0, 1);

    // RAS push/pop
    push(32'h40);  cyc("push_40", 32'h208, 1, 0, 0);
    push(32'h80);  cyc("push_80", 32'h20C, 1, 0, 0);
    ras_pop_i = 1; cyc("pop_80", 32'h80, 1, 0, 0);
    ras_pop_i = 1; cyc("pop_40", 32'h40, 1, 0, 1);
    ras_pop_i = 1; cyc("pop_empty", 32'h44, 1, 0, 1);

    // Overfill a depth-4 stack; the oldest entry is lost
    fetch_ready_i = 1'b0;
    push(32'hA0); cyc("fill_a0", 32'h44, 1, 0, 0);
    push(32'hB0); cyc("fill_b0", 32'h44, 1, 0, 0);
    push(32'hC0); cyc("fill_c0", 32'h44, 1, 0, 0);
    push(32'hD0); cyc("fill_d0", 32'h44, 1, 0, 0);
    push(32'hE0); cyc("fill_e0", 32'h44, 1, 0, 0);
    ras_pop_i = 1; cyc("drain_e0", 32'hE0, 1, 0, 0);
    ras_pop_i = 1; cyc("drain_d0", 32'hD0, 1, 0, 0);
    ras_pop_i = 1; cyc("drain_c0", 32'hC0, 1, 0, 0);
    ras_pop_i = 1; cyc("drain_b0", 32'hB0, 1, 0, 1);
    ras_pop_i = 1; cyc("drain_empty", 32'hB0, 1, 0, 1);

    // Simultaneous push and pop
    push(32'h40); cyc("sp_push_40", 32'hB0, 1, 0, 0);
    push(32'h80); cyc("sp_push_80", 32'hB0, 1, 0, 0);
    push(32'h300); ras_pop_i = 1; cyc("push_pop", 32'h80, 1, 0, 0);
    ras_pop_i = 1; cyc("pop_300", 32'h300, 1, 0, 0);
    ras_pop_i = 1; cyc("pop_40b", 32'h40, 1, 0, 1);

    // Redirect masks a pop; RAS keeps its entry
    push(32'h500); cyc("push_500", 32'h40, 1, 0, 0);
    redir(2'b10, 32'h0, 32'h600); ras_pop_i = 1;
    cyc("redir_over_pop", 32'h600, 1, 0, 0);
    ras_pop_i = 1; cyc("pop_500", 32'h500, 1, 0, 1);

    // Redirect during hold is taken, valid stays low until hold drops
    hold_i = 1'b1; redir(2'b01, 32'h800, 32'h0);
    cyc("redir_in_hold", 32'h800, 0, 0, 1);
    cyc("hold_after_redir", 32'h800, 0, 0, 1);
    hold_i = 1'b0;
    cyc("hold_exit", 32'h800, 1, 0, 1);

    // Address wrap
    redir(2'b01, 32'hFFFF_FFFC, 32'h0);
    cyc("redir_top", 32'hFFFF_FFFC, 1, 0, 1);
    fetch_ready_i = 1'b1;
    cyc("wrap_0", 32'h0, 1, 0, 1);
    cyc("wrap_4", 32'h4, 1, 0, 1);

    // Debug reset mid-operation clears the RAS
    push(32'h700); cyc("push_700", 32'h8, 1, 0, 0);
    jtag_reset_i = 1'b1; cyc("jtag_reset", 32'h0, 0, 0, 1);
    cyc("jtag_release", 32'h0, 1, 0, 1);
    cyc("jtag_stream", 32'h4, 1, 0, 1);
    ras_pop_i = 1; cyc("pop_after_jtag", 32'h8, 1, 0, 1);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
